game_tick_scheduler: RTL and testbench

//   Sequences the snake game's timing resources from CLOCK_50. A run-control FSM
//   (IDLE/RUN/PAUSE/OVER) gates a speed-selectable move-tick divider and a 1 s

---
 rtl/game_tick_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_game_tick_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_scheduler.sv
// Snake game timing: run-control FSM, move-tick and 1 s dividers,
// and a 4-digit BCD elapsed-time counter.
module game_tick_scheduler #(
   parameter int PERIOD_SLOW = 25_000_000,
   parameter int PERIOD_MED  = 10_000_000,
   parameter int PERIOD_FAST = 5_000_000,
   parameter int PERIOD_SEC  = 50_000_000,
   parameter int CW          = 26
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       start,
   input  logic       pause,
   input  logic       game_over,
   input  logic [1:0] speed,
   output logic       tick,
   output logic       sec_tick,
   output logic [1:0] state,
   output logic       running,
   output logic [3:0] bcd0,
   output logic [3:0] bcd1,
   output logic [3:0] bcd2,
   output logic [3:0] bcd3
);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_OVER  = 2'b11;

   localparam logic [CW-1:0] SLOW_LIM = CW'(PERIOD_SLOW - 1);
   localparam logic [CW-1:0] MED_LIM  = CW'(PERIOD_MED - 1);
   localparam logic [CW-1:0] FAST_LIM = CW'(PERIOD_FAST - 1);
   localparam logic [CW-1:0] SEC_LIM  = CW'(PERIOD_SEC - 1);

   logic            start_r;
   logic            pause_r;
   logic            armed;
   logic            start_rise;
   logic            pause_rise;
   logic [1:0]      state_nxt;
   logic            clr;
   logic            cnt_en;
   logic [CW-1:0]   mv_cnt;
   logic [CW-1:0]   sec_cnt;
   logic [CW-1:0]   mv_lim;
   logic [3:0][3:0] bcd_q;
   logic [3:0][3:0] bcd_inc;

   // armed stays low for the first edge after reset so a button held
   // through reset release is seen as a level, not a fresh press
   assign start_rise = armed & start & ~start_r;
   assign pause_rise = armed & pause & ~pause_r;

   assign running = (state == S_RUN);
   assign bcd0    = bcd_q[0];
   assign bcd1    = bcd_q[1];
   assign bcd2    = bcd_q[2];
   assign bcd3    = bcd_q[3];

   // Move period select; speed 10 and 11 both mean fast
   always_comb begin
      mv_lim = FAST_LIM;
      unique case (1'b1)
         speed == 2'b00: mv_lim = SLOW_LIM;
         speed == 2'b01: mv_lim = MED_LIM;
         default:        mv_lim = FAST_LIM;
      endcase
   end

   // Next state; counting only on cycles that stay in RUN
   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      cnt_en    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_rise) begin
               state_nxt = S_RUN;
               clr       = 1'b1;
            end
         end
         S_RUN: begin
            if (game_over) begin
               state_nxt = S_OVER;
            end else if (start_rise) begin
               clr = 1'b1;
            end else if (pause_rise) begin
               state_nxt = S_PAUSE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         S_PAUSE: begin
            if (game_over) begin
               state_nxt = S_OVER;
            end else if (start_rise) begin
               state_nxt = S_RUN;
               clr       = 1'b1;
            end else if (pause_rise) begin
               state_nxt = S_RUN;
            end
         end
         default: begin
            if (start_rise) begin
               state_nxt = S_RUN;
               clr       = 1'b1;
            end
         end
      endcase
   end

   // Ripple BCD increment, 9999 wraps to 0000
   always_comb begin
      logic c;
      c       = 1'b1;
      bcd_inc = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (bcd_q[i] == 4'd9) begin
               bcd_inc[i] = 4'd0;
            end else begin
               bcd_inc[i] = bcd_q[i] + 4'd1;
               c          = 1'b0;
            end
         end
      end
   end

   // FSM state and input edge registers
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state   <= S_IDLE;
         start_r <= 1'b0;
         pause_r <= 1'b0;
         armed   <= 1'b0;
      end else begin
         state   <= state_nxt;
         start_r <= start;
         pause_r <= pause;
         armed   <= 1'b1;
      end
   end

   // Move and second dividers with registered one-cycle pulses
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         mv_cnt   <= '0;
         sec_cnt  <= '0;
         tick     <= 1'b0;
         sec_tick <= 1'b0;
      end else begin
         tick     <= 1'b0;
         sec_tick <= 1'b0;
         if (clr) begin
            mv_cnt  <= '0;
            sec_cnt <= '0;
         end else if (cnt_en) begin
            if (mv_cnt >= mv_lim) begin
               mv_cnt <= '0;
               tick   <= 1'b1;
            end else begin
               mv_cnt <= mv_cnt + CW'(1);
            end
            if (sec_cnt >= SEC_LIM) begin
               sec_cnt  <= '0;
               sec_tick <= 1'b1;
            end else begin
               sec_cnt <= sec_cnt + CW'(1);
            end
         end else if (state_nxt == S_IDLE || state_nxt == S_OVER) begin
            mv_cnt  <= '0;
            sec_cnt <= '0;
         end
      end
   end

   // Elapsed-time digits; held in PAUSE and OVER
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         bcd_q <= '0;
      end else if (clr) begin
         bcd_q <= '0;
      end else if (cnt_en && sec_cnt >= SEC_LIM) begin
         bcd_q <= bcd_inc;
      end
   end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with short sim periods;
// a second instance with a 2-cycle second exercises the 9999 wrap.
module tb_game_tick_scheduler;

   logic       clk = 1'b0;
   logic       resetn, start, pause, game_over;
   logic [1:0] speed;
   logic       tick, sec_tick, running;
   logic [1:0] state;
   logic [3:0] bcd0, bcd1, bcd2, bcd3;

   logic       w_resetn, w_start, w_pause, w_game_over;
   logic [1:0] w_speed;
   logic       w_tick, w_sec_tick, w_running;
   logic [1:0] w_state;
   logic [3:0] w_bcd0, w_bcd1, w_bcd2, w_bcd3;

   int vectors = 0;
   int errs    = 0;

   always #5 clk = ~clk;

   game_tick_scheduler #(
      .PERIOD_SLOW(8), .PERIOD_MED(4), .PERIOD_FAST(2),
      .PERIOD_SEC(10), .CW(26)
   ) u_dut (
      .CLOCK_50(clk), .resetn(resetn), .start(start),
      .pause(pause), .game_over(game_over), .speed(speed),
      .tick(tick), .sec_tick(sec_tick), .state(state),
      .running(running), .bcd0(bcd0), .bcd1(bcd1),
      .bcd2(bcd2), .bcd3(bcd3)
   );

   game_tick_scheduler #(
      .PERIOD_SLOW(8), .PERIOD_MED(4), .PERIOD_FAST(2),
      .PERIOD_SEC(2), .CW(26)
   ) u_wrap (
      .CLOCK_50(clk), .resetn(w_resetn), .start(w_start),
      .pause(w_pause), .game_over(w_game_over), .speed(w_speed),
      .tick(w_tick), .sec_tick(w_sec_tick), .state(w_state),
      .running(w_running), .bcd0(w_bcd0), .bcd1(w_bcd1),
      .bcd2(w_bcd2), .bcd3(w_bcd3)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      resetn = 1'b1; start = 1'b0; pause = 1'b0;
      game_over = 1'b0; speed = 2'b00;
      w_resetn = 1'b1; w_start = 1'b0; w_pause = 1'b0;
      w_game_over = 1'b0; w_speed = 2'b00;
      #1;
      resetn = 1'b0; w_resetn = 1'b0;
      #17;
      chk("rst_state", state, 2'b00);
      chk("rst_pulses", {tick, sec_tick, running}, 3'b000);
      chk("rst_bcd", {bcd3, bcd2, bcd1, bcd0}, 16'h0000);
      #4;
      resetn = 1'b1; w_resetn = 1'b1;
      step(2);

      // IDLE ignores game_over
      game_over = 1'b1;
      step();
      chk("idle_go", state, 2'b00);
      game_over = 1'b0;

      // 1: start, slow speed
      start = 1'b1;
      step();
      chk("t1_state", state, 2'b01);
      chk("t1_run", running, 1'b1);
      chk("t1_tick0", tick, 1'b0);
      start = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         step();
         chk("t1_tick", tick, (k % 8) == 0);
         chk("t1_sec", sec_tick, (k % 10) == 0);
      end
      chk("t1_bcd", {bcd3, bcd2, bcd1, bcd0}, 16'h0002);

      // 2: restart and cross 99 -> 100
      start = 1'b1;
      step();
      chk("t2_clr", {bcd3, bcd2, bcd1, bcd0}, 16'h0000);
      start = 1'b0;
      step(989);
      chk("t2_pre", sec_tick, 1'b0);
      step();
      chk("t2_sec99", sec_tick, 1'b1);
      chk("t2_99", {bcd3, bcd2, bcd1, bcd0}, 16'h0099);
      step(10);
      chk("t2_100", {bcd3, bcd2, bcd1, bcd0}, 16'h0100);

      // 3: pause at move count 5
      start = 1'b1;
      step();
      start = 1'b0;
      step(5);
      pause = 1'b1;
      step();
      chk("t3_pstate", state, 2'b10);
      chk("t3_ptick", {tick, sec_tick}, 2'b00);
      for (int k = 0; k < 20; k++) begin
         step();
         chk("t3_hold", {state, tick, sec_tick}, 4'b1000);
      end
      pause = 1'b0;
      step();
      chk("t3_rel", state, 2'b10);
      pause = 1'b1;
      step();
      chk("t3_resume", state, 2'b01);
      chk("t3_rtick", tick, 1'b0);
      pause = 1'b0;
      step();
      chk("t3_r1", tick, 1'b0);
      step();
      chk("t3_r2", tick, 1'b0);
      step();
      chk("t3_r3", tick, 1'b1);
      step();
      chk("t3_r4sec", sec_tick, 1'b0);
      step();
      chk("t3_r5sec", sec_tick, 1'b1);
      chk("t3_bcd", {bcd3, bcd2, bcd1, bcd0}, 16'h0001);

      // 4: speed change with move count 6
      step(4);
      speed = 2'b10;
      step();
      chk("t4_imm", tick, 1'b1);
      step();
      chk("t4_f1", tick, 1'b0);
      step();
      chk("t4_f2", tick, 1'b1);
      step();
      chk("t4_f3", tick, 1'b0);
      step();
      chk("t4_f4", tick, 1'b1);
      speed = 2'b01;
      step();
      chk("t4_m1", tick, 1'b0);
      chk("t4_sec", sec_tick, 1'b1);
      chk("t4_bcd", {bcd3, bcd2, bcd1, bcd0}, 16'h0002);
      step();
      chk("t4_m2", tick, 1'b0);
      step();
      chk("t4_m3", tick, 1'b0);
      step();
      chk("t4_m4", tick, 1'b1);

      // 5: game_over wins over start and pause
      game_over = 1'b1; start = 1'b1; pause = 1'b1;
      step();
      chk("t5_over", state, 2'b11);
      chk("t5_pulse", {tick, sec_tick, running}, 3'b000);
      chk("t5_bcd", {bcd3, bcd2, bcd1, bcd0}, 16'h0002);
      game_over = 1'b0; start = 1'b0; pause = 1'b0;
      step();
      pause = 1'b1;
      step();
      chk("t5_pign", state, 2'b11);
      pause = 1'b0;
      step(3);
      chk("t5_hold", {bcd3, bcd2, bcd1, bcd0}, 16'h0002);
      speed = 2'b10;
      start = 1'b1;
      step();
      chk("t5_restart", state, 2'b01);
      chk("t5_clr", {bcd3, bcd2, bcd1, bcd0}, 16'h0000);
      start = 1'b0;

      // 6: async reset mid-run, start held across release
      step(12);
      chk("t6_pre_tick", tick, 1'b1);
      chk("t6_pre_bcd", {bcd3, bcd2, bcd1, bcd0}, 16'h0001);
      #2;
      resetn = 1'b0;
      #1;
      chk("t6_state", state, 2'b00);
      chk("t6_pulse", {tick, sec_tick, running}, 3'b000);
      chk("t6_bcd", {bcd3, bcd2, bcd1, bcd0}, 16'h0000);
      start = 1'b1;
      #2;
      resetn = 1'b1;
      step();
      chk("t6_held1", state, 2'b00);
      step(3);
      chk("t6_held2", state, 2'b00);
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      chk("t6_press", state, 2'b01);
      start = 1'b0;

      // 9999 -> 0000 wrap on the fast-second instance
      w_start = 1'b1;
      step();
      chk("w_state", w_state, 2'b01);
      w_start = 1'b0;
      step(19998);
      chk("w_9999", {w_bcd3, w_bcd2, w_bcd1, w_bcd0}, 16'h9999);
      step();
      chk("w_mid", {w_sec_tick, w_bcd3, w_bcd2, w_bcd1, w_bcd0},
          17'h09999);
      step();
      chk("w_wrap", {w_sec_tick, w_bcd3, w_bcd2, w_bcd1, w_bcd0},
          17'h10000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
